// File: rtl/machina_pkg.sv
// Shared types and saturating arithmetic helpers for the perceptron layer.
package machina_pkg;

   typedef enum logic {
      ACT_STEP,
      ACT_RELU
   } act_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FWD,
      S_ACT,
      S_RES,
      S_WAIT_ERR,
      S_BWD,
      S_FBK
   } state_t;

   localparam int WGT_FRAC = 8;
   localparam int UNIT     = 255;

   function automatic logic signed [63:0] clamp_s(input logic signed [63:0] v,
                                                  input logic signed [63:0] lo,
                                                  input logic signed [63:0] hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   // Clamp a wide signed value into the range of a w-bit two's complement number.
   function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      return clamp_s(v, -hi - 64'sd1, hi);
   endfunction

endpackage

// File: rtl/neuron_mac.sv
// One neuron: weight/bias register file, serial MAC, activation and weight update.
module neuron_mac
   import machina_pkg::*;
#(
   parameter int   ARGN       = 2,
   parameter int   ARG_WIDTH  = 8,
   parameter int   RES_WIDTH  = 8,
   parameter int   WGT_WIDTH  = 16,
   parameter int   ERR_WIDTH  = 16,
   parameter int   RATE_SHIFT = 8,
   parameter int   IDX_W      = 2,
   parameter act_t ACT_SEL    = ACT_STEP
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr_i,
   input  logic                        mac_i,
   input  logic                        upd_i,
   input  logic [IDX_W-1:0]            idx_i,
   input  logic [ARG_WIDTH-1:0]        x_i,
   input  logic signed [ERR_WIDTH-1:0] err_i,
   output logic signed [WGT_WIDTH-1:0] wgt_o,
   output logic [RES_WIDTH-1:0]        res_o
);
   localparam int ACC_W  = ARG_WIDTH + WGT_WIDTH + $clog2(ARGN + 1);
   localparam int PROD_W = ARG_WIDTH + WGT_WIDTH + 1;

   logic signed [WGT_WIDTH-1:0] wgt_q [ARGN+1];
   logic signed [WGT_WIDTH-1:0] wgt_d;
   logic signed [ACC_W-1:0]     acc_q, acc_d;
   logic signed [ARG_WIDTH:0]   x_s;
   logic signed [PROD_W-1:0]    prod;
   logic signed [63:0]          upd_sum;

   assign x_s   = $signed({1'b0, x_i});
   assign wgt_o = wgt_q[idx_i];
   assign prod  = wgt_o * x_s;

   always_comb begin
      // NOTE: default first so every path assigns acc_d; a missing branch would infer a latch.
      acc_d = acc_q;
      if (clr_i)      acc_d = '0;
      else if (mac_i) acc_d = acc_q + ACC_W'(prod);
   end

   assign upd_sum = 64'(wgt_o) + ((64'(err_i) * 64'(x_s)) >>> RATE_SHIFT);
   assign wgt_d   = WGT_WIDTH'(sat_s(upd_sum, WGT_WIDTH));

   always_comb begin
      res_o = '0;
      if (ACT_SEL == ACT_RELU)
         res_o = RES_WIDTH'(clamp_s(64'(acc_q) >>> WGT_FRAC, 64'sd0, 64'(UNIT)));
      else if (!acc_q[ACC_W-1] && (acc_q != '0))
         res_o = RES_WIDTH'(UNIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the weight file is reset explicitly so a reset always yields an untrained neuron; it stays in flops, not RAM.
         for (int i = 0; i <= ARGN; i++) wgt_q[i] <= '0;
         acc_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every reader this cycle on the pre-edge weight.
         acc_q <= acc_d;
         if (upd_i) wgt_q[idx_i] <= wgt_d;
      end
   end

endmodule

// File: rtl/perceptron_layer.sv
// Layer of RESN perceptrons sharing one argument vector; owns the FSM, handshakes,
// element index and the cross-neuron feedback sum.
module perceptron_layer
   import machina_pkg::*;
#(
   parameter int ARGN       = 2,
   parameter int RESN       = 1,
   parameter int ARG_WIDTH  = 8,
   parameter int RES_WIDTH  = 8,
   parameter int WGT_WIDTH  = 16,
   parameter int ERR_WIDTH  = 16,
   parameter int FBK_WIDTH  = 16,
   parameter int RATE_SHIFT = 8,
   parameter     ACT        = "STEP"
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      arg_valid,
   output logic                      arg_ready,
   input  logic [ARGN*ARG_WIDTH-1:0] arg_data,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [RESN*RES_WIDTH-1:0] res_data,
   input  logic                      err_valid,
   output logic                      err_ready,
   input  logic [RESN*ERR_WIDTH-1:0] err_data,
   output logic                      fbk_valid,
   input  logic                      fbk_ready,
   output logic [ARGN*FBK_WIDTH-1:0] fbk_data
);
   localparam int               IDX_W    = $clog2(ARGN + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ARGN);
   localparam act_t             ACT_SEL  = (ACT == "RELU") ? ACT_RELU : ACT_STEP;

   state_t                      state_q, state_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [ARGN*ARG_WIDTH-1:0]   arg_q;
   logic [RESN*ERR_WIDTH-1:0]   err_q;
   logic [RESN*RES_WIDTH-1:0]   res_q;
   logic [ARGN*FBK_WIDTH-1:0]   fbk_q;
   logic                        clr, mac, upd, arg_ld, err_ld, res_ld, fbk_ld;
   logic                        last;
   logic [ARG_WIDTH-1:0]        x_sel;
   logic signed [WGT_WIDTH-1:0] wgt_rd [RESN];
   logic [RES_WIDTH-1:0]        res_w  [RESN];
   logic signed [63:0]          fbk_sum;
   logic [FBK_WIDTH-1:0]        fbk_new;

   // The element after the last argument is the bias, driven with x = 1.0.
   assign last  = (idx_q == IDX_LAST);
   assign x_sel = last ? {ARG_WIDTH{1'b1}} : arg_q[idx_q*ARG_WIDTH +: ARG_WIDTH];

   for (genvar g = 0; g < RESN; g++) begin : g_neuron
      neuron_mac #(
         .ARGN      (ARGN),
         .ARG_WIDTH (ARG_WIDTH),
         .RES_WIDTH (RES_WIDTH),
         .WGT_WIDTH (WGT_WIDTH),
         .ERR_WIDTH (ERR_WIDTH),
         .RATE_SHIFT(RATE_SHIFT),
         .IDX_W     (IDX_W),
         .ACT_SEL   (ACT_SEL)
      ) u_mac (
         .clk  (clk),
         .rst  (rst),
         .clr_i(clr),
         .mac_i(mac),
         .upd_i(upd),
         .idx_i(idx_q),
         .x_i  (x_sel),
         .err_i($signed(err_q[g*ERR_WIDTH +: ERR_WIDTH])),
         .wgt_o(wgt_rd[g]),
         .res_o(res_w[g])
      );
   end

   always_comb begin
      fbk_sum = '0;
      for (int j = 0; j < RESN; j++)
         fbk_sum = fbk_sum + 64'($signed(err_q[j*ERR_WIDTH +: ERR_WIDTH])) * 64'(wgt_rd[j]);
      fbk_new = FBK_WIDTH'(sat_s(fbk_sum >>> WGT_FRAC, FBK_WIDTH));
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      arg_ready = 1'b0;
      res_valid = 1'b0;
      err_ready = 1'b0;
      fbk_valid = 1'b0;
      clr       = 1'b0;
      mac       = 1'b0;
      upd       = 1'b0;
      arg_ld    = 1'b0;
      err_ld    = 1'b0;
      res_ld    = 1'b0;
      fbk_ld    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            arg_ready = 1'b1;
            if (arg_valid) begin
               arg_ld  = 1'b1;
               clr     = 1'b1;
               idx_d   = '0;
               state_d = S_FWD;
            end
         end
         S_FWD: begin
            mac = 1'b1;
            if (last) begin
               idx_d   = '0;
               state_d = S_ACT;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_ACT: begin
            res_ld  = 1'b1;
            state_d = S_RES;
         end
         S_RES: begin
            res_valid = 1'b1;
            if (res_ready) state_d = en ? S_WAIT_ERR : S_IDLE;
         end
         S_WAIT_ERR: begin
            err_ready = 1'b1;
            if (err_valid) begin
               err_ld  = 1'b1;
               idx_d   = '0;
               state_d = S_BWD;
            end
         end
         S_BWD: begin
            upd    = 1'b1;
            fbk_ld = !last;
            if (last) begin
               idx_d   = '0;
               state_d = S_FBK;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_FBK: begin
            fbk_valid = 1'b1;
            if (fbk_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         arg_q   <= '0;
         err_q   <= '0;
         res_q   <= '0;
         fbk_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (arg_ld) arg_q <= arg_data;
         if (err_ld) err_q <= err_data;
         if (res_ld)
            for (int j = 0; j < RESN; j++) res_q[j*RES_WIDTH +: RES_WIDTH] <= res_w[j];
         if (fbk_ld) fbk_q[idx_q*FBK_WIDTH +: FBK_WIDTH] <= fbk_new;
      end
   end

   assign res_data = res_q;
   assign fbk_data = fbk_q;

endmodule

// File: tb/tb_perceptron_layer.sv
// Self-checking bench: a two-neuron STEP layer and a one-neuron RELU layer run in
// lockstep against a plain-arithmetic model of weights, activations and feedback.
module tb_perceptron_layer;

   logic        clk        = 1'b0;
   logic        rst        = 1'b1;
   logic        en         = 1'b0;
   logic        arg_valid  = 1'b0;
   logic [15:0] arg_data   = '0;
   logic        res_ready  = 1'b0;
   logic        err_valid  = 1'b0;
   logic        fbk_ready  = 1'b0;
   logic [31:0] s_err_data = '0;
   logic [15:0] r_err_data = '0;

   logic        s_arg_ready, s_res_valid, s_err_ready, s_fbk_valid;
   logic [15:0] s_res_data;
   logic [31:0] s_fbk_data;
   logic        r_arg_ready, r_res_valid, r_err_ready, r_fbk_valid;
   logic [7:0]  r_res_data;
   logic [31:0] r_fbk_data;

   int     n_tests = 0;
   int     n_fail  = 0;
   longint ws [2][3];
   longint wr [3];
   longint xs [2];

   always #5 clk = ~clk;

   perceptron_layer #(.ARGN(2), .RESN(2), .ACT("STEP")) u_step (
      .clk(clk), .rst(rst), .en(en),
      .arg_valid(arg_valid), .arg_ready(s_arg_ready), .arg_data(arg_data),
      .res_valid(s_res_valid), .res_ready(res_ready), .res_data(s_res_data),
      .err_valid(err_valid), .err_ready(s_err_ready), .err_data(s_err_data),
      .fbk_valid(s_fbk_valid), .fbk_ready(fbk_ready), .fbk_data(s_fbk_data)
   );

   perceptron_layer #(.ARGN(2), .RESN(1), .ACT("RELU")) u_relu (
      .clk(clk), .rst(rst), .en(en),
      .arg_valid(arg_valid), .arg_ready(r_arg_ready), .arg_data(arg_data),
      .res_valid(r_res_valid), .res_ready(res_ready), .res_data(r_res_data),
      .err_valid(err_valid), .err_ready(r_err_ready), .err_data(r_err_data),
      .fbk_valid(r_fbk_valid), .fbk_ready(fbk_ready), .fbk_data(r_fbk_data)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic longint sat16(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic longint x_of(input int k);
      return (k == 2) ? 255 : xs[k];
   endfunction

   function automatic longint model_step(input int j);
      longint a;
      a = ws[j][0] * x_of(0) + ws[j][1] * x_of(1) + ws[j][2] * x_of(2);
      return (a > 0) ? 255 : 0;
   endfunction

   function automatic longint model_relu();
      longint a;
      a = wr[0] * x_of(0) + wr[1] * x_of(1) + wr[2] * x_of(2);
      a = a >>> 8;
      if (a < 0)   return 0;
      if (a > 255) return 255;
      return a;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         ws[0][k] = 0;
         ws[1][k] = 0;
         wr[k]    = 0;
      end
   endfunction

   // ---------------- transactions ----------------
   task automatic fwd(input int a0, input int a1, input bit en_v, input int hold);
      int          cyc;
      int          bad;
      logic [15:0] snap_s;
      logic [7:0]  snap_r;
      xs[0] = a0;
      xs[1] = a1;
      check("arg_ready_idle", longint'(s_arg_ready), 1);
      arg_data  = {8'(a1), 8'(a0)};
      arg_valid = 1'b1;
      @(posedge clk);
      #1 arg_valid = 1'b0;
      cyc = 0;
      while (s_res_valid !== 1'b1 && cyc < 50) begin
         @(posedge clk);
         #1 cyc++;
      end
      check("res_latency", longint'(cyc), 4);
      check("relu_res_valid", longint'(r_res_valid), 1);
      check("res_step_n0", longint'(s_res_data[7:0]), model_step(0));
      check("res_step_n1", longint'(s_res_data[15:8]), model_step(1));
      check("res_relu", longint'(r_res_data), model_relu());
      snap_s = s_res_data;
      snap_r = r_res_data;
      bad    = 0;
      for (int i = 0; i < hold; i++) begin
         arg_valid = 1'($urandom);
         arg_data  = 16'($urandom);
         err_valid = 1'($urandom);
         @(posedge clk);
         #1;
         if (s_res_valid !== 1'b1 || r_res_valid !== 1'b1 || s_res_data !== snap_s ||
             r_res_data !== snap_r || s_arg_ready !== 1'b0 || r_arg_ready !== 1'b0)
            bad++;
      end
      arg_valid = 1'b0;
      err_valid = 1'b0;
      if (hold > 0) check("res_hold_stable", longint'(bad), 0);
      en        = en_v;
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      en = 1'b0;
      check("res_valid_drop", longint'(s_res_valid), 0);
      check("post_res_ready", longint'(en_v ? s_err_ready : s_arg_ready), 1);
   endtask

   task automatic bwd(input longint e0, input longint e1, input longint er, input int hold);
      longint      fs [2];
      longint      fr [2];
      int          cyc;
      int          bad;
      logic [31:0] snap_s;
      logic [31:0] snap_r;
      for (int k = 0; k < 2; k++) begin
         fs[k] = sat16((e0 * ws[0][k] + e1 * ws[1][k]) >>> 8);
         fr[k] = sat16((er * wr[k]) >>> 8);
      end
      for (int k = 0; k < 3; k++) begin
         ws[0][k] = sat16(ws[0][k] + ((e0 * x_of(k)) >>> 8));
         ws[1][k] = sat16(ws[1][k] + ((e1 * x_of(k)) >>> 8));
         wr[k]    = sat16(wr[k] + ((er * x_of(k)) >>> 8));
      end
      check("err_ready_wait", longint'(s_err_ready), 1);
      s_err_data = {16'(e1), 16'(e0)};
      r_err_data = 16'(er);
      err_valid  = 1'b1;
      @(posedge clk);
      #1 err_valid = 1'b0;
      cyc = 0;
      while (s_fbk_valid !== 1'b1 && cyc < 50) begin
         @(posedge clk);
         #1 cyc++;
      end
      check("fbk_latency", longint'(cyc), 3);
      check("relu_fbk_valid", longint'(r_fbk_valid), 1);
      check("fbk_step_0", longint'($signed(s_fbk_data[15:0])), fs[0]);
      check("fbk_step_1", longint'($signed(s_fbk_data[31:16])), fs[1]);
      check("fbk_relu_0", longint'($signed(r_fbk_data[15:0])), fr[0]);
      check("fbk_relu_1", longint'($signed(r_fbk_data[31:16])), fr[1]);
      snap_s = s_fbk_data;
      snap_r = r_fbk_data;
      bad    = 0;
      for (int i = 0; i < hold; i++) begin
         arg_valid = 1'($urandom);
         arg_data  = 16'($urandom);
         err_valid = 1'($urandom);
         @(posedge clk);
         #1;
         if (s_fbk_valid !== 1'b1 || r_fbk_valid !== 1'b1 || s_fbk_data !== snap_s ||
             r_fbk_data !== snap_r || s_arg_ready !== 1'b0 || s_err_ready !== 1'b0)
            bad++;
      end
      arg_valid = 1'b0;
      err_valid = 1'b0;
      if (hold > 0) check("fbk_hold_stable", longint'(bad), 0);
      fbk_ready = 1'b1;
      @(posedge clk);
      #1 fbk_ready = 1'b0;
      check("fbk_valid_drop", longint'(s_fbk_valid), 0);
      check("post_fbk_idle", longint'(s_arg_ready), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          pa0 [4]     = '{0, 255, 0, 255};
      int          pa1 [4]     = '{0, 0, 255, 255};
      longint      tgt_and [4] = '{0, 0, 0, 255};
      longint      tgt_or [4]  = '{0, 255, 255, 255};
      logic signed [15:0] t0, t1, t2;
      bit          en_r;

      // Reset values
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_arg_ready", longint'(s_arg_ready), 1);
      check("rst_res_valid", longint'(s_res_valid), 0);
      check("rst_err_ready", longint'(s_err_ready), 0);
      check("rst_fbk_valid", longint'(s_fbk_valid), 0);
      check("rst_res_data", longint'(s_res_data), 0);
      check("rst_fbk_data", longint'(s_fbk_data), 0);
      fwd(255, 255, 1'b0, 0);
      check("zero_wgt_res", longint'(s_res_data), 0);

      // Update/feedback arithmetic from zero weights
      fwd(255, 0, 1'b1, 0);
      bwd(255, 255, 255, 0);
      check("first_fbk_zero", longint'(r_fbk_data), 0);
      fwd(0, 0, 1'b0, 0);
      check("relu_bias_only", longint'(r_res_data), 253);
      fwd(255, 0, 1'b1, 0);
      check("step_after_update", longint'(s_res_data[7:0]), 255);
      bwd(-255, -255, -255, 0);
      check("relu_fbk0_neg", longint'($signed(r_fbk_data[15:0])), -254);
      check("relu_fbk1_zero", longint'($signed(r_fbk_data[31:16])), 0);

      // Backpressure on both result and feedback streams
      fwd(255, 255, 1'b1, 20);
      bwd(1000, -700, 300, 20);

      // Reset in the second backward cycle
      fwd(255, 0, 1'b1, 0);
      s_err_data = {16'sd500, 16'sd500};
      r_err_data = 16'sd500;
      err_valid  = 1'b1;
      @(posedge clk);
      #1 err_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midbwd_arg_ready", longint'(s_arg_ready), 1);
      check("midbwd_res_valid", longint'(s_res_valid), 0);
      check("midbwd_err_ready", longint'(s_err_ready), 0);
      check("midbwd_fbk_valid", longint'(s_fbk_valid), 0);
      check("midbwd_res_data", longint'(s_res_data), 0);
      check("midbwd_fbk_data", longint'(s_fbk_data), 0);
      check("midbwd_relu_res", longint'(r_res_data), 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      fwd(255, 255, 1'b0, 0);
      check("midbwd_fwd_step", longint'(s_res_data), 0);
      check("midbwd_fwd_relu", longint'(r_res_data), 0);

      // AND / OR training, error = target - result
      for (int ep = 0; ep < 10; ep++) begin
         for (int p = 0; p < 4; p++) begin
            fwd(pa0[p], pa1[p], 1'b1, 0);
            bwd(tgt_and[p] - model_step(0), tgt_or[p] - model_step(1),
                tgt_and[p] - model_relu(), 0);
         end
      end
      for (int p = 0; p < 4; p++) begin
         fwd(pa0[p], pa1[p], 1'b0, 0);
         check("trained_and", longint'(s_res_data[7:0]), tgt_and[p]);
         check("trained_or", longint'(s_res_data[15:8]), tgt_or[p]);
      end

      // Randomized traffic with saturating errors and short stalls
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         en_r = 1'($urandom);
         fwd(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), en_r,
             int'($urandom_range(0, 3)));
         if (en_r) begin
            t0 = 16'($urandom);
            t1 = 16'($urandom);
            t2 = 16'($urandom);
            bwd(longint'(t0), longint'(t1), longint'(t2), int'($urandom_range(0, 3)));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/perceptron_layer.md
Name: perceptron_layer

Overview:
- Parametrised successor to the single perceptron: RESN neurons share one ARGN-element argument vector, each with its own trainable weights and bias.
- Sequential MAC processes one argument element per cycle, all neurons in parallel. Activation is selectable: step or clamped ReLU.
- When trained (en=1), it accepts a per-neuron error vector, updates the weights and returns a back-propagated feedback vector for stacking layers.
- Sits between upstream arg producers and downstream error/feedback consumers using valid/ready streams.

Parameters:
- ARGN, 2, number of argument elements
- RESN, 1, number of neurons
- ARG_WIDTH, 8, unsigned argument width; 255 represents 1.0
- RES_WIDTH, 8, unsigned result width
- WGT_WIDTH, 16, signed weight width, Q(WGT_WIDTH-8).8
- ERR_WIDTH, 16, signed error width
- FBK_WIDTH, 16, signed feedback width
- RATE_SHIFT, 8, learning-rate right shift
- ACT, "STEP", activation: "STEP" or "RELU"

Ports:
- clk  in  1  clock
- rst  in  1  reset (asynchronous, active-high)
- en  in  1  training enable; sampled at the result handshake
- arg_valid  in  1  argument valid
- arg_ready  out  1  argument ready
- arg_data  in  ARGN*ARG_WIDTH  argument vector, element i at [i*ARG_WIDTH +: ARG_WIDTH]
- res_valid  out  1  result valid
- res_ready  in  1  result ready
- res_data  out  RESN*RES_WIDTH  result vector
- err_valid  in  1  error valid
- err_ready  out  1  error ready
- err_data  in  RESN*ERR_WIDTH  signed per-neuron error
- fbk_valid  out  1  feedback valid
- fbk_ready  in  1  feedback ready
- fbk_data  out  ARGN*FBK_WIDTH  signed per-argument feedback

Behaviour:
- Single clock, clk. Reset is asynchronous and active-high on rst.
- Reset:
  - state=IDLE, all weights and biases=0
  - arg_ready=1, res_valid=0, err_ready=0, fbk_valid=0
  - res_data=0, fbk_data=0
  - Reset in any state, including mid-FWD/BWD, aborts the operation and produces the same values.
- States: IDLE -> FWD -> ACT -> RES -> (WAIT_ERR -> BWD -> FBK ->) IDLE.
- IDLE:
  - arg_ready=1.
  - On arg_valid&arg_ready, latch arg_data and go to FWD. A transfer occurs only on valid&ready.
- FWD:
  - ARGN+1 cycles, k=0..ARGN. k=ARGN is the bias with x=255.
  - acc_j += w_jk * x_k.
  - acc width is ARG_WIDTH+WGT_WIDTH+clog2(ARGN+1); no overflow possible.
- ACT (1 cycle):
  - STEP: res_j = acc_j>0 ? 255 : 0, with strict >.
  - RELU: res_j = clamp(acc_j>>>8, 0, 255).
- RES:
  - res_valid=1. res_data is held stable until res_ready.
  - res_valid rises ARGN+2 cycles after the accepting edge.
  - arg_ready=0 from the accept until return to IDLE.
- At the res handshake: en=0 -> IDLE; en=1 -> WAIT_ERR.
- WAIT_ERR: err_ready=1. On the err handshake, latch err_data and go to BWD.
- BWD: ARGN+1 cycles, k=0..ARGN.
  - fbk_k = sat_FBK((sum_j err_j*w_jk) >>> 8), using pre-update weights. Bias has no feedback.
  - w_jk = sat_WGT(w_jk + ((err_j*x_k) >>> RATE_SHIFT)). Shifts are arithmetic (floor).
- FBK:
  - fbk_valid=1. fbk_data is held until fbk_ready, then IDLE.
  - fbk_valid rises ARGN+1 cycles after the err handshake.
- No overlap: a new argument is never accepted before the FBK (train) or RES (infer) handshake completes.
- Valid inputs outside their accepting state are ignored.
- Weight saturation clamps to [-2^(WGT_WIDTH-1), 2^(WGT_WIDTH-1)-1]; feedback saturation likewise to FBK_WIDTH.

Decomposition:
- Package machina_pkg: act_t enum (ACT_STEP, ACT_RELU), state_t enum, WGT_FRAC=8 constant, sat/clamp functions.
- Sub-module neuron_mac: one neuron's weight register file (ARGN+1 entries), MAC accumulator, activation and update adder. Instantiated RESN times.
- Top owns the FSM, the handshakes, the index counter and the feedback adder tree across neurons.

Test Plan:
- Reset values (ARGN=2, RESN=1, STEP):
  - after rst: arg_ready=1, res_valid=0, err_ready=0, fbk_valid=0.
  - en=0, arg {255,255} -> res 0, with res_valid exactly 4 cycles after accept.
- AND training (RESN=1, STEP):
  - en=1, 10 epochs over {0,0},{255,0},{0,255},{255,255}, targets {0,0,0,255}, err=tgt-res.
  - then en=0: all four results equal their targets.
- AND/OR concurrent (RESN=2): same training with targets per neuron -> res_data = {AND, OR} for every pattern afterwards.
- Update/feedback arithmetic, from zero weights, en=1:
  - arg {255,0}, err +255 -> fbk {0,0}; w0=254, w1=0, bias=254.
  - arg {255,0} again -> res 255.
  - err -255 -> fbk_0=-254, fbk_1=0.
  - RELU variant after the first update: arg {0,0} -> res 253.
- Backpressure:
  - hold res_ready=0 for 20 cycles -> res_valid and res_data stable, arg_ready=0, arg_valid pulses ignored.
  - same check for fbk with fbk_ready=0.
- Reset mid-BWD: assert rst in the 2nd BWD cycle -> all outputs at reset values, weights zero, next forward of {255,255} -> res 0.
